// File: rtl/div_issue_unit.sv
// Divider issue unit: launches the external divider for DIV/DIVU, applies sign fix-up and owns HI/LO.
// Optional macro DIV_ZERO_TRAP_EN adds a div_zero_exc pulse and suppresses the HI/LO write on divide by zero.
module div_issue_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             div_zero_exc
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FIXUP  = 2'd3
  } state_t;

  localparam logic [1:0]       OP_DIVU = 2'b00;
  localparam logic [1:0]       OP_DIV  = 2'b01;
  localparam logic [1:0]       OP_MTHI = 2'b10;
  localparam logic [1:0]       OP_MTLO = 2'b11;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_raw_q, q_raw_d;
  logic [WIDTH-1:0] r_raw_q, r_raw_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`ifdef DIV_ZERO_TRAP_EN
  logic             zero_exc_q, zero_exc_d;
`endif

  // Two's-complement negate, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  // Magnitude of a signed operand; the most negative value maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    q_raw_d    = q_raw_q;
    r_raw_d    = r_raw_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
`ifdef DIV_ZERO_TRAP_EN
    zero_exc_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: begin
              if (rt_val == ZERO) begin
`ifdef DIV_ZERO_TRAP_EN
                zero_exc_d = 1'b1;
`else
                hi_d = rs_val;
                lo_d = '1;
`endif
              end else if (op_code == OP_DIV) begin
                dividend_d = magnitude(rs_val);
                divisor_d  = magnitude(rt_val);
                neg_q_d    = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
                neg_r_d    = rs_val[WIDTH-1];
                state_d    = LAUNCH;
              end else begin
                dividend_d = rs_val;
                divisor_d  = rt_val;
                neg_q_d    = 1'b0;
                neg_r_d    = 1'b0;
                state_d    = LAUNCH;
              end
            end
          endcase
        end
      end
      LAUNCH: state_d = WAIT;
      // done is only honoured here, so a level left high from a previous divide cannot be captured early
      WAIT: begin
        if (div_done) begin
          q_raw_d = div_quotient;
          r_raw_d = div_remainder;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        lo_d    = neg_q_q ? negate(q_raw_q) : q_raw_q;
        hi_d    = neg_r_q ? negate(r_raw_q) : r_raw_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      q_raw_q    <= '0;
      r_raw_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      zero_exc_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      q_raw_q    <= q_raw_d;
      r_raw_q    <= r_raw_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`ifdef DIV_ZERO_TRAP_EN
      zero_exc_q <= zero_exc_d;
`endif
    end
  end

  assign div_start    = (state_q == LAUNCH);
  assign busy         = (state_q != IDLE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_exc = zero_exc_q;
`endif

endmodule

// File: tb/tb_div_issue_unit.sv
// Bench for div_issue_unit: vector table, corner sequences and randomized ops against a signed-arithmetic model.
module tb_div_issue_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_exc;
`endif

  div_issue_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .busy(busy), .hi(hi), .lo(lo)
`ifdef DIV_ZERO_TRAP_EN
    , .div_zero_exc(div_zero_exc)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural result of an op, from signed/unsigned arithmetic on the operands.
  task automatic model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output bit launch, output logic [31:0] mag_a, output logic [31:0] mag_b);
    longint a, b;
    launch = 0; mag_a = '0; mag_b = '0;
    if (op == 2'b10) m_hi = rs;
    else if (op == 2'b11) m_lo = rs;
    else if (rt == 0) begin
`ifndef DIV_ZERO_TRAP_EN
      m_hi = rs;
      m_lo = 32'hFFFF_FFFF;
`endif
    end else if (op == 2'b00) begin
      launch = 1; mag_a = rs; mag_b = rt;
      m_lo = rs / rt;
      m_hi = rs % rt;
    end else begin
      launch = 1;
      a = $signed(rs);
      b = $signed(rt);
      mag_a = 32'((a < 0) ? -a : a);
      mag_b = 32'((b < 0) ? -b : b);
      m_lo = 32'(a / b);
      m_hi = 32'(a % b);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input int lat);
    bit launch;
    logic [31:0] ea, eb, old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    model(op, rs, rt, launch, ea, eb);
    @(negedge CLK);
    op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt;
    @(negedge CLK);
    op_valid = 1'b0;
    if (!launch) begin
      chk("busy_single", {31'b0, busy}, 32'd0);
      chk("start_single", {31'b0, div_start}, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
      chk("zero_exc", {31'b0, div_zero_exc}, {31'b0, (op[1] == 1'b0) && (rt == 0)});
`endif
      chk("hi_single", hi, m_hi);
      chk("lo_single", lo, m_lo);
    end else begin
      chk("start_launch", {31'b0, div_start}, 32'd1);
      chk("busy_launch", {31'b0, busy}, 32'd1);
      chk("dividend", div_dividend, ea);
      chk("divisor", div_divisor, eb);
      @(negedge CLK);
      chk("start_wait", {31'b0, div_start}, 32'd0);
      chk("hi_hold", hi, old_hi);
      chk("lo_hold", lo, old_lo);
      repeat (lat - 1) @(negedge CLK);
      div_done = 1'b1;
      div_quotient = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
      @(negedge CLK);
      div_done = 1'b0;
      div_quotient = $urandom; div_remainder = $urandom;
      chk("busy_fixup", {31'b0, busy}, 32'd1);
      @(negedge CLK);
      chk("busy_done", {31'b0, busy}, 32'd0);
      chk("hi_result", hi, m_hi);
      chk("lo_result", lo, m_lo);
    end
  endtask

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 32'd100,        32'd7,          2, 32'd2,          32'd14};
    tbl[1]  = '{2'b01, 32'hFFFF_FFF9,  32'd2,          1, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
    tbl[2]  = '{2'b01, 32'd7,          32'hFFFF_FFFE,  3, 32'd1,          32'hFFFF_FFFD};
    tbl[3]  = '{2'b11, 32'h1234,       32'd0,          1, 32'd1,          32'h1234};
`ifdef DIV_ZERO_TRAP_EN
    tbl[4]  = '{2'b00, 32'h55,         32'd0,          1, 32'd1,          32'h1234};
`else
    tbl[4]  = '{2'b00, 32'h55,         32'd0,          1, 32'h55,         32'hFFFF_FFFF};
`endif
    tbl[5]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  4, 32'd0,          32'h8000_0000};
    tbl[6]  = '{2'b10, 32'hABCD,       32'd3,          1, 32'hABCD,       32'h8000_0000};
    tbl[7]  = '{2'b01, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  2, 32'hFFFF_FFFE,  32'd2};
    tbl[8]  = '{2'b01, 32'd0,          32'd5,          1, 32'd0,          32'd0};
    tbl[9]  = '{2'b00, 32'hFFFF_FFFF,  32'd16,         5, 32'hF,          32'h0FFF_FFFF};
`ifdef DIV_ZERO_TRAP_EN
    tbl[10] = '{2'b01, 32'hFFFF_FFF0,  32'd0,          1, 32'hF,          32'h0FFF_FFFF};
`else
    tbl[10] = '{2'b01, 32'hFFFF_FFF0,  32'd0,          1, 32'hFFFF_FFF0,  32'hFFFF_FFFF};
`endif

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_start", {31'b0, div_start}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    RST = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].lat);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].eh);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].el);
    end

    // Done left high during LAUNCH must not be captured
    begin
      logic [31:0] oh, ol;
      oh = m_hi; ol = m_lo;
      m_hi = 32'd0; m_lo = 32'd10;
      @(negedge CLK);
      op_valid = 1'b1; op_code = 2'b00; rs_val = 32'd50; rt_val = 32'd5;
      @(negedge CLK);
      op_valid = 1'b0;
      div_done = 1'b1; div_quotient = 32'hDEAD; div_remainder = 32'hBEEF;
      @(negedge CLK);
      div_done = 1'b0;
      chk("stale_busy1", {31'b0, busy}, 32'd1);
      @(negedge CLK);
      chk("stale_busy2", {31'b0, busy}, 32'd1);
      chk("stale_hi_hold", hi, oh);
      chk("stale_lo_hold", lo, ol);
      div_done = 1'b1; div_quotient = 32'd10; div_remainder = 32'd0;
      @(negedge CLK);
      div_done = 1'b0;
      @(negedge CLK);
      chk("stale_busy_end", {31'b0, busy}, 32'd0);
      chk("stale_hi", hi, m_hi);
      chk("stale_lo", lo, m_lo);
    end

    // MTHI during WAIT is ignored
    begin
      m_hi = 32'd0; m_lo = 32'd11;
      @(negedge CLK);
      op_valid = 1'b1; op_code = 2'b00; rs_val = 32'd77; rt_val = 32'd7;
      @(negedge CLK);
      op_valid = 1'b0;
      @(negedge CLK);
      op_valid = 1'b1; op_code = 2'b10; rs_val = 32'hFFFF;
      @(negedge CLK);
      op_valid = 1'b0;
      chk("ign_hi_wait", hi, 32'd0);
      div_done = 1'b1; div_quotient = 32'd11; div_remainder = 32'd0;
      @(negedge CLK);
      div_done = 1'b0;
      @(negedge CLK);
      chk("ign_busy", {31'b0, busy}, 32'd0);
      chk("ign_hi", hi, m_hi);
      chk("ign_lo", lo, m_lo);
    end

    // Asynchronous reset mid-WAIT, then a late done
    begin
      @(negedge CLK);
      op_valid = 1'b1; op_code = 2'b01; rs_val = 32'd1000; rt_val = 32'd9;
      @(negedge CLK);
      op_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_start", {31'b0, div_start}, 32'd0);
      chk("mrst_hi", hi, 32'd0);
      chk("mrst_lo", lo, 32'd0);
      chk("mrst_divisor", div_divisor, 32'd0);
      m_hi = '0; m_lo = '0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      div_done = 1'b1; div_quotient = 32'd5; div_remainder = 32'd5;
      @(negedge CLK);
      div_done = 1'b0;
      @(negedge CLK);
      chk("late_busy", {31'b0, busy}, 32'd0);
      chk("late_hi", hi, 32'd0);
      chk("late_lo", lo, 32'd0);
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [31:0] rs, rt;
      int k;
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) rs = 32'h8000_0000;
      else if (k == 1) rs = 32'($urandom_range(0, 20));
      k = $urandom_range(0, 7);
      if (k == 0) rt = 32'd0;
      else if (k == 1) rt = 32'hFFFF_FFFF;
      else if (k == 2) rt = 32'($urandom_range(1, 9));
      else if (k == 3) rt = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
      do_op(op, rs, rt, $urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
